// File: rtl/pcie_axi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module : pcie_axi_sram_pkg
// Brief  : Shared encodings, FSM state type and beat-address helper for the
//          PCIe AXI SRAM read pipe.
// Rev    : 1.0
// ============================================================================
package pcie_axi_sram_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'd0;
    localparam logic [1:0] c_BURST_INCR  = 2'd1;
    localparam logic [1:0] c_BURST_WRAP  = 2'd2;
    localparam logic [1:0] c_BURST_RSVD  = 2'd3;

    localparam logic [1:0] c_RESP_OKAY   = 2'd0;
    localparam logic [1:0] c_RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // Byte address of the beat following addr; WRAP folds back into the
    // (len_m1+1)<<size container holding addr.
    function automatic logic [63:0] next_beat_addr(
        input logic [63:0] addr,
        input logic [2:0]  size,
        input logic [3:0]  len_m1,
        input logic [1:0]  burst
    );
        logic [63:0] step;
        logic [63:0] mask;
        logic [63:0] nxt;
        step = 64'd1 << size;
        mask = ((64'(len_m1) + 64'd1) << size) - 64'd1;
        nxt  = addr + step;
        case (burst)
            c_BURST_FIXED: nxt = addr;
            c_BURST_WRAP:  nxt = (addr & ~mask) | (nxt & mask);
            default:       nxt = addr + step;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_axi_rd_skid.sv
`default_nettype none
// ============================================================================
// Module : pcie_axi_rd_skid
// Brief  : 2-entry fall-through skid buffer for the R channel payload.
// Rev    : 1.0
// ============================================================================
module pcie_axi_rd_skid #(
    parameter int PAY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [PAY_W-1:0] i_data,
    output logic             o_valid,
    output logic [PAY_W-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_count
);

    logic [PAY_W-1:0] r_mem [2];
    logic             r_head;
    logic [1:0]       r_cnt;
    logic             w_empty;
    logic             w_store;
    logic             w_deq;
    logic             w_tail;

    // Empty buffer passes the incoming beat straight through; the producer
    // never offers a beat while both entries are occupied.
    assign w_empty = (r_cnt == 2'd0);
    assign o_valid = !w_empty || i_valid;
    assign o_data  = w_empty ? i_data : r_mem[r_head];
    assign w_deq   = !w_empty && i_ready;
    assign w_store = i_valid && !(w_empty && i_ready);
    assign w_tail  = r_head ^ r_cnt[0];
    assign o_count = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_deq) begin
                r_head <= ~r_head;
            end
            r_cnt <= r_cnt + {1'b0, w_store} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_tail] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcie_axi_sram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module : pcie_axi_sram_rd_pipe
// Brief  : Pipelined single-burst AXI read slave over a 1-cycle SRAM.
//          Define AXI_SRAM_RD_WRAP_EN to support WRAP bursts.
// Rev    : 1.0
// ============================================================================
module pcie_axi_sram_rd_pipe
    import pcie_axi_sram_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 64,
    parameter int SRAM_AW = 10,
    parameter int LEN_W   = 12,
    parameter int ID_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               axi_arvalid,
    input  logic [ID_W-1:0]    axi_arid,
    input  logic [ADDR_W-1:0]  axi_araddr,
    input  logic [LEN_W-1:0]   axi_arlen,
    input  logic [2:0]         axi_arsize,
    input  logic [1:0]         axi_arburst,
    output logic               axi_arready,
    output logic               axi_rvalid,
    output logic [ID_W-1:0]    axi_rid,
    output logic [DATA_W-1:0]  axi_rdata,
    output logic [1:0]         axi_rresp,
    output logic               axi_rlast,
    input  logic               axi_rready,
    output logic               sram_ren,
    output logic [SRAM_AW-1:0] sram_raddr,
    input  logic [DATA_W-1:0]  sram_rdata,
    output logic               busy
);

    localparam int c_BYTE_SHIFT = $clog2(DATA_W / 8);
    localparam int c_PAY_W      = ID_W + DATA_W + 3;

    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [ID_W-1:0]    r_id;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [2:0]         r_size;
    logic [1:0]         r_burst;
    logic               r_berr;
    logic [LEN_W:0]     r_beat;
    logic               r_inf_vld;
    logic               r_inf_err;
    logic               r_inf_last;

    logic               w_ar_hs;
    logic               w_ar_err;
    logic               w_wrap_ok;
    logic               w_issue;
    logic               w_beat_err;
    logic               w_last_issue;
    logic               w_r_done;
    logic [1:0]         w_skid_cnt;
    logic [DATA_W-1:0]  w_beat_data;
    logic [c_PAY_W-1:0] w_skid_in;
    logic [c_PAY_W-1:0] w_skid_out;

`ifdef AXI_SRAM_RD_WRAP_EN
    assign w_wrap_ok = (axi_arlen == LEN_W'(1)) || (axi_arlen == LEN_W'(3)) ||
                       (axi_arlen == LEN_W'(7)) || (axi_arlen == LEN_W'(15));
`else
    assign w_wrap_ok = 1'b0;
`endif

    assign w_ar_err = (32'(axi_arsize) > c_BYTE_SHIFT) ||
                      (axi_arburst == c_BURST_RSVD) ||
                      ((axi_arburst == c_BURST_WRAP) && !w_wrap_ok);

    assign axi_arready = (r_state == ST_IDLE) && !rst;
    assign w_ar_hs     = axi_arvalid && axi_arready;
    assign busy        = (r_state != ST_IDLE);

    // Beats past the SRAM end error individually instead of wrapping to word 0.
    assign w_beat_err   = r_berr || (|r_addr[ADDR_W-1:SRAM_AW+c_BYTE_SHIFT]);
    assign w_issue      = (r_state == ST_ISSUE) &&
                          (({1'b0, w_skid_cnt} + {2'b00, r_inf_vld}) < 3'd2);
    assign w_last_issue = (r_beat == {1'b0, r_len});
    assign sram_ren     = w_issue && !w_beat_err;
    assign sram_raddr   = r_addr[c_BYTE_SHIFT +: SRAM_AW];
    assign w_r_done     = axi_rvalid && axi_rready && axi_rlast;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_ar_hs)                   w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_issue && w_last_issue)   w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_r_done)                  w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= 3'd0;
            r_burst    <= 2'd0;
            r_berr     <= 1'b0;
            r_beat     <= '0;
            r_inf_vld  <= 1'b0;
            r_inf_err  <= 1'b0;
            r_inf_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ar_hs) begin
                r_id    <= axi_arid;
                r_addr  <= axi_araddr;
                r_len   <= axi_arlen;
                r_size  <= axi_arsize;
                r_burst <= axi_arburst;
                r_berr  <= w_ar_err;
                r_beat  <= '0;
            end else if (w_issue) begin
                r_beat <= r_beat + {{LEN_W{1'b0}}, 1'b1};
                r_addr <= ADDR_W'(next_beat_addr(64'(r_addr), r_size, r_len[3:0], r_burst));
            end
            // One-cycle SRAM latency stage: the beat joins the skid next cycle.
            r_inf_vld  <= w_issue;
            r_inf_err  <= w_beat_err;
            r_inf_last <= w_last_issue;
        end
    end

    assign w_beat_data = r_inf_err ? {DATA_W{1'b0}} : sram_rdata;
    assign w_skid_in   = r_inf_vld ?
                         {r_id, w_beat_data, (r_inf_err ? c_RESP_SLVERR : c_RESP_OKAY), r_inf_last} :
                         {c_PAY_W{1'b0}};

    pcie_axi_rd_skid #(
        .PAY_W (c_PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_inf_vld),
        .i_data  (w_skid_in),
        .o_valid (axi_rvalid),
        .o_data  (w_skid_out),
        .i_ready (axi_rready),
        .o_count (w_skid_cnt)
    );

    assign {axi_rid, axi_rdata, axi_rresp, axi_rlast} = w_skid_out;

endmodule
`default_nettype wire

// File: tb/tb_pcie_axi_sram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_pcie_axi_sram_rd_pipe
// Brief  : Directed self-checking bench with a burst-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_pcie_axi_sram_rd_pipe;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 64;
    localparam int SRAM_AW = 10;
    localparam int LEN_W   = 12;
    localparam int ID_W    = 4;
    localparam int PAY_W   = ID_W + DATA_W + 3;

    logic               clk;
    logic               rst;
    logic               axi_arvalid;
    logic [ID_W-1:0]    axi_arid;
    logic [ADDR_W-1:0]  axi_araddr;
    logic [LEN_W-1:0]   axi_arlen;
    logic [2:0]         axi_arsize;
    logic [1:0]         axi_arburst;
    logic               axi_arready;
    logic               axi_rvalid;
    logic [ID_W-1:0]    axi_rid;
    logic [DATA_W-1:0]  axi_rdata;
    logic [1:0]         axi_rresp;
    logic               axi_rlast;
    logic               axi_rready;
    logic               sram_ren;
    logic [SRAM_AW-1:0] sram_raddr;
    logic [DATA_W-1:0]  sram_rdata;
    logic               busy;

    pcie_axi_sram_rd_pipe #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .SRAM_AW (SRAM_AW), .LEN_W (LEN_W), .ID_W (ID_W)
    ) dut (
        .clk (clk), .rst (rst),
        .axi_arvalid (axi_arvalid), .axi_arid (axi_arid), .axi_araddr (axi_araddr),
        .axi_arlen (axi_arlen), .axi_arsize (axi_arsize), .axi_arburst (axi_arburst),
        .axi_arready (axi_arready),
        .axi_rvalid (axi_rvalid), .axi_rid (axi_rid), .axi_rdata (axi_rdata),
        .axi_rresp (axi_rresp), .axi_rlast (axi_rlast), .axi_rready (axi_rready),
        .sram_ren (sram_ren), .sram_raddr (sram_raddr), .sram_rdata (sram_rdata),
        .busy (busy)
    );

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    logic [DATA_W-1:0] mem [1024];
    beat_t             exp_q[$];
    int                exp_ren_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cyc = -1, first_ren = -1, first_rv = -1, last_rv = -1;
    int ren_cnt = 0, slv_cnt = 0, rbeats = 0, outst = 0, max_out = 0;
    int rmode = 0;
    logic [ID_W-1:0]  last_rid = '0;
    logic             stall = 1'b0;
    logic [PAY_W-1:0] held = '0;
    logic [PAY_W-1:0] pay;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: data only the cycle after a read, junk otherwise.
    always @(posedge clk) begin
        sram_rdata <= sram_ren ? mem[sram_raddr] : {8{32'hDEADBEEF}};
    end

    initial begin
        axi_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 1) axi_rready = ~axi_rready;
            else            axi_rready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_burst(input logic [ID_W-1:0] id, input logic [63:0] addr,
                               input int len, input int size, input int burst);
        logic [63:0] step, cont, base, a;
        bit          berr, err, wrap_ok;
        beat_t       b;
        step    = 64'd1 << size;
        cont    = 64'(len + 1) * step;
        base    = addr - (addr % cont);
        wrap_ok = 1'b0;
`ifdef AXI_SRAM_RD_WRAP_EN
        wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
`endif
        berr = (size > 5) || (burst == 3) || ((burst == 2) && !wrap_ok);
        for (int i = 0; i <= len; i++) begin
            case (burst)
                0:       a = addr;
                2:       a = base + ((addr - base + 64'(i) * step) % cont);
                default: a = addr + 64'(i) * step;
            endcase
            err    = berr || (a >= 64'd32768);
            b.id   = id;
            b.data = '0;
            if (!err) b.data = mem[int'(a >> 5)];
            b.resp = err ? 2'd2 : 2'd0;
            b.last = (i == len);
            exp_q.push_back(b);
            if (!err) exp_ren_q.push_back(int'(a >> 5));
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_ren_q.delete();
            stall = 1'b0;
            outst = 0;
        end else begin
            pay = {axi_rid, axi_rdata, axi_rresp, axi_rlast};
            if (stall) chk("r_hold_stable", {axi_rvalid, pay}, {1'b1, held});
            if (sram_ren) begin
                ren_cnt++;
                outst++;
                if (first_ren < 0) first_ren = cyc;
                if (exp_ren_q.size() == 0) chk("ren_unexpected", 32'(exp_ren_q.size()), 32'd1);
                else                       chk("sram_raddr", sram_raddr, exp_ren_q.pop_front());
            end
            if (axi_rvalid && axi_rready) begin
                rbeats++;
                last_rv  = cyc;
                last_rid = axi_rid;
                if (first_rv < 0) first_rv = cyc;
                if (axi_rresp == 2'd2) slv_cnt++;
                else                   outst--;
                if (exp_q.size() == 0) chk("r_unexpected_beat", 32'(exp_q.size()), 32'd1);
                else                   chk("r_beat", pay, exp_q.pop_front());
            end
            if (outst > max_out) max_out = outst;
            stall = axi_rvalid && !axi_rready;
            held  = pay;
            if (axi_arvalid && axi_arready) hs_cyc = cyc;
        end
    end

    task automatic clear_stats;
        ren_cnt = 0; slv_cnt = 0; rbeats = 0; max_out = 0;
        first_ren = -1; first_rv = -1; last_rv = -1; hs_cyc = -1;
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [63:0] addr,
                           input int len, input int size, input int burst);
        @(posedge clk);
        #1;
        axi_arid    = id;
        axi_araddr  = addr;
        axi_arlen   = LEN_W'(len);
        axi_arsize  = 3'(size);
        axi_arburst = 2'(burst);
        axi_arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (axi_arready) break;
        end
        chk("ar_accept", axi_arready, 1'b1);
        @(posedge clk);
        #1;
        axi_arvalid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            #1;
            done = (exp_q.size() == 0) && !busy;
        end
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_ren_drained"}, 32'(exp_ren_q.size()), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e_ren, e_slv, nerr;
        for (int i = 0; i < 1024; i++)
            for (int k = 0; k < 8; k++)
                mem[i][k*32 +: 32] = {16'(i), 8'(k), 8'hC3};
        rst = 1'b1; axi_arvalid = 1'b0; axi_arid = '0; axi_araddr = '0;
        axi_arlen = '0; axi_arsize = 3'd0; axi_arburst = 2'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rvalid", axi_rvalid, 1'b0);
        chk("reset_ren", sram_ren, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_arready", axi_arready, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("arready_after_reset", axi_arready, 1'b1);

        // INCR 0x40, rready=1: words 2..5, fixed latency, back-to-back beats
        clear_stats;
        model_burst(4'h3, 64'h40, 3, 5, 1);
        chk("t1_model_words", {exp_ren_q[0], exp_ren_q[1], exp_ren_q[2], exp_ren_q[3]},
            {32'd2, 32'd3, 32'd4, 32'd5});
        send_ar(4'h3, 64'h40, 3, 5, 1);
        wait_done(100, "t1");
        chk("t1_ren_latency", first_ren - hs_cyc, 1);
        chk("t1_rvalid_latency", first_rv - hs_cyc, 2);
        chk("t1_back_to_back", last_rv - first_rv, 3);
        chk("t1_ren_count", ren_cnt, 4);

        // Same burst with rready toggling
        clear_stats;
        rmode = 1;
        model_burst(4'h3, 64'h40, 3, 5, 1);
        send_ar(4'h3, 64'h40, 3, 5, 1);
        wait_done(200, "t2");
        rmode = 0;
        chk("t2_beats", rbeats, 4);
        chk("t2_outstanding_le2", (max_out > 2) ? max_out : 2, 2);

        // FIXED, id echo
        clear_stats;
        model_burst(4'hA, 64'h20, 2, 5, 0);
        chk("t3_model_words", {exp_ren_q[0], exp_ren_q[1], exp_ren_q[2]}, {32'd1, 32'd1, 32'd1});
        send_ar(4'hA, 64'h20, 2, 5, 0);
        wait_done(100, "t3");
        chk("t3_rid", last_rid, 4'hA);
        chk("t3_ren_count", ren_cnt, 3);

        // INCR running off the SRAM end
        clear_stats;
        model_burst(4'h5, 64'h7FC0, 3, 5, 1);
        nerr = 0;
        foreach (exp_q[i]) if (exp_q[i].resp == 2'd2) nerr++;
        chk("t4_model_err_beats", nerr, 2);
        send_ar(4'h5, 64'h7FC0, 3, 5, 1);
        wait_done(100, "t4");
        chk("t4_ren_count", ren_cnt, 2);
        chk("t4_slverr_count", slv_cnt, 2);

        // Oversize arsize
        clear_stats;
        model_burst(4'h1, 64'h0, 1, 6, 1);
        send_ar(4'h1, 64'h0, 1, 6, 1);
        wait_done(100, "t5a");
        chk("t5a_ren_count", ren_cnt, 0);
        chk("t5a_slverr_count", slv_cnt, 2);

        // Reserved burst type
        clear_stats;
        model_burst(4'h2, 64'h80, 1, 5, 3);
        send_ar(4'h2, 64'h80, 1, 5, 3);
        wait_done(100, "t5b");
        chk("t5b_ren_count", ren_cnt, 0);
        chk("t5b_slverr_count", slv_cnt, 2);

        // WRAP
        clear_stats;
        model_burst(4'h6, 64'h60, 3, 5, 2);
`ifdef AXI_SRAM_RD_WRAP_EN
        chk("t5c_model_words", {exp_ren_q[0], exp_ren_q[1], exp_ren_q[2], exp_ren_q[3]},
            {32'd3, 32'd0, 32'd1, 32'd2});
        e_ren = 4; e_slv = 0;
`else
        e_ren = 0; e_slv = 4;
`endif
        send_ar(4'h6, 64'h60, 3, 5, 2);
        wait_done(100, "t5c");
        chk("t5c_ren_count", ren_cnt, e_ren);
        chk("t5c_slverr_count", slv_cnt, e_slv);

        // Narrow INCR (4-byte beats): words 1,2,2,2
        clear_stats;
        model_burst(4'h7, 64'h3C, 3, 2, 1);
        chk("t5d_model_words", {exp_ren_q[0], exp_ren_q[1], exp_ren_q[2], exp_ren_q[3]},
            {32'd1, 32'd2, 32'd2, 32'd2});
        send_ar(4'h7, 64'h3C, 3, 2, 1);
        wait_done(100, "t5d");
        chk("t5d_beats", rbeats, 4);

        // Reset after the 2nd beat of an 8-beat burst
        clear_stats;
        model_burst(4'h8, 64'h0, 7, 5, 1);
        send_ar(4'h8, 64'h0, 7, 5, 1);
        for (int n = 0; n < 100 && rbeats < 2; n++) begin
            @(negedge clk);
            #1;
        end
        chk("t6_two_beats_seen", rbeats, 2);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rvalid_after_rst", axi_rvalid, 1'b0);
        chk("t6_busy_after_rst", busy, 1'b0);
        chk("t6_ren_after_rst", sram_ren, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_arready_after_rst", axi_arready, 1'b1);
        chk("t6_no_more_beats", rbeats, 2);
        clear_stats;
        model_burst(4'h9, 64'h100, 1, 5, 1);
        send_ar(4'h9, 64'h100, 1, 5, 1);
        wait_done(100, "t6b");
        chk("t6b_ren_count", ren_cnt, 2);
        chk("t6b_beats", rbeats, 2);

        // Maximum length burst, byte-sized beats
        clear_stats;
        model_burst(4'hF, 64'h0, 4095, 0, 1);
        send_ar(4'hF, 64'h0, 4095, 0, 1);
        wait_done(5000, "t7");
        chk("t7_beats", rbeats, 4096);
        chk("t7_ren_count", ren_cnt, 4096);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
